// File: rtl/coproc_pkg.sv
// coproc_pkg: shared definitions for the coprocessor command sequencer.
//   state_t            - sequencer FSM states
//   SEL_W / SEL_STATUS - coprocessor select width and the reserved status select
//   entry_width()      - packed FIFO entry width {rd, sel, a, b, c} for a data width
//   MIN_ISSUE_INTERVAL - fastest go-to-go spacing (y already idle at first poll)
//   READ_EXTRA_CYCLES  - extra cycles a result-capturing command costs
package coproc_pkg;

    localparam int SEL_W = 11;
    localparam logic [SEL_W-1:0] SEL_STATUS = 11'd0;

    localparam int MIN_ISSUE_INTERVAL = 5;
    localparam int READ_EXTRA_CYCLES  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_GO,
        ST_SETTLE,
        ST_POLL,
        ST_READ,
        ST_CAPT
    } state_t;

    function automatic int entry_width(input int width);
        return 1 + SEL_W + 3 * width;
    endfunction

endpackage

// File: rtl/coproc_cmd_fifo.sv
// coproc_cmd_fifo: synchronous first-word-fall-through FIFO for queued commands.
//   clk, arstn      - clock, asynchronous active-low reset (pointers only)
//   wr_en, wr_data  - write request; ignored while full
//   rd_en, rd_data  - pop request; rd_data always shows the head entry
//   full, empty     - status flags
// Pointers carry one extra wrap bit so full and empty are distinguishable
// across the 2^DEPTH_LOG2 entries.
module coproc_cmd_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                do_wr;
    logic                do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples its inputs from the same pre-edge values.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone
    // define which entries are valid, so clearing data would only cost logic.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[DEPTH_LOG2-1:0]];

endmodule

// File: rtl/coproc_seq.sv
// coproc_seq: queues CPU commands and issues them to coproc one at a time,
// waiting for the coprocessor's busy word (y under select 0) to clear.
//   clk, arstn                    - clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           - enqueue handshake (ready = FIFO not full)
//   cmd_sel, cmd_rd, cmd_a/b/c    - command: select, capture-result flag, operands
//   cp_sel, cp_go, cp_a/b/c, cp_y - coprocessor port
//   res_valid, res_data           - captured result pulse / held result word
//   busy                          - FIFO non-empty or a command in flight
//   err                           - sticky watchdog error
// Optional feature: define COPROC_SEQ_TIMEOUT_EN to add a TMO_BITS watchdog on
// the busy poll; without it err is tied low and polling waits indefinitely.
module coproc_seq
    import coproc_pkg::*;
#(
    parameter int WIDTH      = 18,
    parameter int DEPTH_LOG2 = 2
`ifdef COPROC_SEQ_TIMEOUT_EN
    ,
    parameter int TMO_BITS   = 12
`endif
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [10:0]      cmd_sel,
    input  logic             cmd_rd,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [WIDTH-1:0] cmd_c,
    output logic [10:0]      cp_sel,
    output logic             cp_go,
    output logic [WIDTH-1:0] cp_a,
    output logic [WIDTH-1:0] cp_b,
    output logic [WIDTH-1:0] cp_c,
    input  logic [WIDTH-1:0] cp_y,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             busy,
    output logic             err
);

    localparam int ENTRY_W = entry_width(WIDTH);

    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_rd;
    logic [ENTRY_W-1:0] fifo_wr_data;
    logic [ENTRY_W-1:0] fifo_rd_data;

    logic               head_rd;
    logic [SEL_W-1:0]   head_sel;
    logic [WIDTH-1:0]   head_a;
    logic [WIDTH-1:0]   head_b;
    logic [WIDTH-1:0]   head_c;

    state_t             state;
    logic               cur_rd;
    logic [SEL_W-1:0]   cur_sel;

    assign fifo_wr_data = {cmd_rd, cmd_sel, cmd_a, cmd_b, cmd_c};
    assign {head_rd, head_sel, head_a, head_b, head_c} = fifo_rd_data;

    assign cmd_ready = !fifo_full;
    assign fifo_rd   = (state == ST_IDLE) && !fifo_empty;
    assign busy      = !fifo_empty || (state != ST_IDLE);

    coproc_cmd_fifo #(
        .WIDTH      (ENTRY_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .arstn   (arstn),
        .wr_en   (cmd_valid),
        .wr_data (fifo_wr_data),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

`ifdef COPROC_SEQ_TIMEOUT_EN
    // Abandon the poll on the edge where the counter steps onto all-ones.
    localparam logic [TMO_BITS-1:0] TMO_PRE = {{(TMO_BITS-1){1'b1}}, 1'b0};
    logic [TMO_BITS-1:0] tmo_cnt;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state     <= ST_IDLE;
            cp_sel    <= SEL_STATUS;
            cp_go     <= 1'b0;
            cp_a      <= '0;
            cp_b      <= '0;
            cp_c      <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            cur_rd    <= 1'b0;
            cur_sel   <= SEL_STATUS;
`ifdef COPROC_SEQ_TIMEOUT_EN
            tmo_cnt   <= '0;
            err       <= 1'b0;
`endif
        end else begin
            // Pulse outputs default low; only the state that owns them raises them.
            cp_go     <= 1'b0;
            res_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        cp_sel  <= head_sel;
                        cur_sel <= head_sel;
                        cur_rd  <= head_rd;
                        cp_a    <= head_a;
                        cp_b    <= head_b;
                        cp_c    <= head_c;
                        state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    // A status-select command has nothing to start.
                    if (cur_sel == SEL_STATUS) begin
                        state <= ST_IDLE;
                    end else begin
                        cp_go <= 1'b1;
                        state <= ST_GO;
                    end
                end
                ST_GO: begin
                    cp_sel <= SEL_STATUS;
                    state  <= ST_SETTLE;
`ifdef COPROC_SEQ_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                end
                ST_SETTLE: state <= ST_POLL;
                ST_POLL: begin
                    if (cp_y == '0) begin
                        if (cur_rd) begin
                            cp_sel <= cur_sel;
                            state  <= ST_READ;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
`ifdef COPROC_SEQ_TIMEOUT_EN
                    else if (tmo_cnt == TMO_PRE) begin
                        err   <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                ST_READ: begin
                    res_data  <= cp_y;
                    res_valid <= 1'b1;
                    cp_sel    <= SEL_STATUS;
                    state     <= ST_CAPT;
                end
                ST_CAPT: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coproc_seq.sv
// tb_coproc_seq: directed self-checking bench for coproc_seq with a
// behavioural coprocessor that stays busy model_lat cycles after each go.
module tb_coproc_seq;
    import coproc_pkg::*;

    localparam int WIDTH      = 18;
    localparam int DEPTH_LOG2 = 2;

    logic             clk;
    logic             arstn;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [10:0]      cmd_sel;
    logic             cmd_rd;
    logic [WIDTH-1:0] cmd_a, cmd_b, cmd_c;
    logic [10:0]      cp_sel;
    logic             cp_go;
    logic [WIDTH-1:0] cp_a, cp_b, cp_c;
    logic [WIDTH-1:0] cp_y;
    logic             res_valid;
    logic [WIDTH-1:0] res_data;
    logic             busy;
    logic             err;

    coproc_seq #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
`ifdef COPROC_SEQ_TIMEOUT_EN
        ,
        .TMO_BITS   (4)
`endif
    ) dut (
        .clk       (clk),
        .arstn     (arstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_sel   (cmd_sel),
        .cmd_rd    (cmd_rd),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_c     (cmd_c),
        .cp_sel    (cp_sel),
        .cp_go     (cp_go),
        .cp_a      (cp_a),
        .cp_b      (cp_b),
        .cp_c      (cp_c),
        .cp_y      (cp_y),
        .res_valid (res_valid),
        .res_data  (res_data),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural coprocessor.
    int model_lat;
    bit model_forever;
    int model_cnt;

    always @(posedge clk or negedge arstn) begin
        if (!arstn)                              model_cnt <= 0;
        else if (cp_go)                          model_cnt <= model_forever ? 1 : model_lat;
        else if (model_cnt > 0 && !model_forever) model_cnt <= model_cnt - 1;
    end

    always_comb begin
        cp_y = '0;
        case (cp_sel)
            11'h000: cp_y = (model_cnt != 0) ? 18'd1 : 18'd0;
            11'h018: cp_y = 18'o777371;
            11'h078: cp_y = 18'h155;
            default: cp_y = '0;
        endcase
    end

    // Monitor, sampled on the falling edge.
    int cyc = 0;
    int go_cyc[$];
    int res_pulses = 0;
    bit prev_go = 1'b0;
    bit go_rule_bad = 1'b0;
    bit bad_sel_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cp_go) begin
            if (prev_go || cp_sel == 11'd0) go_rule_bad = 1'b1;
            go_cyc.push_back(cyc);
        end
        prev_go = cp_go;
        if (cp_sel == 11'h7FF) bad_sel_seen = 1'b1;
        if (res_valid) res_pulses++;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [10:0] sel, input logic rd,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] c);
        cmd_valid = 1'b1;
        cmd_sel   = sel;
        cmd_rd    = rd;
        cmd_a     = a;
        cmd_b     = b;
        cmd_c     = c;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check(tag, busy, 1'b0);
    endtask

    task automatic wait_ready(input int budget, input string tag);
        int n = 0;
        while (!cmd_ready && n < budget) begin
            tick();
            n++;
        end
        check(tag, cmd_ready, 1'b1);
    endtask

    int base;
    int rbase;
    int min_gap;

    initial begin
        arstn = 1'b0; cmd_valid = 1'b0; cmd_sel = '0; cmd_rd = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_c = '0;
        model_lat = 0; model_forever = 1'b0;

        // Reset values.
        tick(); tick();
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_ctrl_outs", {cp_go, cp_sel, res_valid, busy, err}, '0);
        check("rst_operands", cp_a | cp_b | cp_c, '0);
        check("rst_res_data", res_data, '0);
        arstn = 1'b1;
        tick(); tick();

        // Single command, immediate idle: go on the third cycle counting the
        // enqueue cycle, sequencer idle five edges after the enqueue edge.
        base = go_cyc.size();
        push(11'h018, 1'b0, 18'o777371, 18'o001116, 18'd0);
        check("t1_go_low_e0", cp_go, 1'b0);
        tick();
        check("t1_go_low_e1", cp_go, 1'b0);
        tick();
        check("t1_go_high", cp_go, 1'b1);
        check("t1_go_sel", cp_sel, 11'h018);
        check("t1_go_a", cp_a, 18'o777371);
        check("t1_go_b", cp_b, 18'o001116);
        tick();
        check("t1_settle_go_low", cp_go, 1'b0);
        check("t1_settle_sel", cp_sel, 11'd0);
        check("t1_settle_a_held", cp_a, 18'o777371);
        tick();
        check("t1_poll_busy", busy, 1'b1);
        tick();
        check("t1_idle_busy", busy, 1'b0);
        check("t1_go_count", go_cyc.size() - base, 1);

        // Status-select command is accepted but never pulses go.
        base = go_cyc.size();
        push(11'd0, 1'b0, 18'd5, 18'd6, 18'd7);
        repeat (6) tick();
        check("t_sel0_no_go", go_cyc.size() - base, 0);
        check("t_sel0_busy", busy, 1'b0);

        // Ten commands with a 7-cycle busy; fill the FIFO, try a dropped push.
        model_lat = 7;
        base = go_cyc.size();
        for (int i = 0; i < 5; i++) push(11'h058, 1'b0, 18'(i), 18'd0, 18'd0);
        check("t2_full_ready_low", cmd_ready, 1'b0);
        push(11'h7FF, 1'b0, 18'h3FFFF, 18'd0, 18'd0);
        check("t2_still_full", cmd_ready, 1'b0);
        for (int i = 5; i < 10; i++) begin
            wait_ready(100, "t2_ready_timeout");
            push(11'h058, 1'b0, 18'(i), 18'd0, 18'd0);
        end
        wait_idle(500, "t2_idle_timeout");
        check("t2_go_count", go_cyc.size() - base, 10);
        min_gap = 1000;
        for (int i = base + 1; i < go_cyc.size(); i++)
            if (go_cyc[i] - go_cyc[i-1] < min_gap) min_gap = go_cyc[i] - go_cyc[i-1];
        check("t2_min_gap_ge_11", (min_gap >= 7 + 4), 1'b1);
        check("t2_dropped_sel_unseen", bad_sel_seen, 1'b0);

        // Result capture.
        model_lat = 0;
        rbase = res_pulses;
        push(11'h078, 1'b1, 18'o26, 18'd0, 18'd0);
        wait_idle(50, "t3_idle_timeout");
        check("t3_res_pulses", res_pulses - rbase, 1);
        check("t3_res_data", res_data, 18'h155);
        repeat (3) tick();
        check("t3_res_hold", res_data, 18'h155);
        check("t3_res_valid_low", res_valid, 1'b0);
        check("t3_sel_status", cp_sel, 11'd0);

        // Reset during POLL with a second command queued.
        model_forever = 1'b1;
        push(11'h058, 1'b0, 18'd1, 18'd2, 18'd3);
        push(11'h018, 1'b0, 18'd4, 18'd5, 18'd6);
        tick(); tick(); tick();
        check("t4_in_poll_busy", busy, 1'b1);
        arstn = 1'b0;
        #1;
        check("t4_rst_ready", cmd_ready, 1'b1);
        check("t4_rst_ctrl", {cp_go, cp_sel, res_valid, busy, err}, '0);
        check("t4_rst_data", cp_a | cp_b | cp_c | res_data, '0);
        model_forever = 1'b0;
        base = go_cyc.size();
        tick(); tick();
        arstn = 1'b1;
        repeat (10) tick();
        check("t4_no_go_after", go_cyc.size() - base, 0);
        check("t4_fifo_empty", busy, 1'b0);

`ifdef COPROC_SEQ_TIMEOUT_EN
        // Watchdog: coprocessor never idles; 15 poll cycles then abandon.
        model_forever = 1'b1;
        push(11'h018, 1'b0, 18'd1, 18'd0, 18'd0);
        push(11'h058, 1'b0, 18'd2, 18'd0, 18'd0);
        repeat (17) tick();
        check("t5_err_not_yet", err, 1'b0);
        tick();
        check("t5_err_set", err, 1'b1);
        tick(); tick();
        check("t5_next_go", cp_go, 1'b1);
        check("t5_next_sel", cp_sel, 11'h058);
        model_forever = 1'b0;
        model_lat = 0;
        wait_idle(100, "t5_idle_timeout");
        check("t5_err_sticky", err, 1'b1);
`else
        check("t_err_tied_low", err, 1'b0);
`endif

        check("go_rules", go_rule_bad, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
